// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - IF0 redirect/stall sequencer with EX redirect replay across PC freezes
// Optional perf counters: define FETCH_REDIRECT_PERF_EN
module fetch_redirect_ctrl #(
    parameter int              WORD     = 32,
    parameter logic [WORD-1:0] RESET_PC = 32'h1C000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pre_branch,
    input  logic [WORD-1:0] pre_pc,
    input  logic            ex_branch,
    input  logic [WORD-1:0] ex_pc,
    input  logic            stall_icache,
    input  logic            stall_load,
    input  logic            stall_dcache,
    output logic            if0_pre_branch,
    output logic [WORD-1:0] if0_pre_pc,
    output logic            if0_ex_branch,
    output logic [WORD-1:0] if0_ex_pc,
    output logic            if0_pc_stall,
    output logic            flush_if,
    output logic            redirect_pending,
    output logic [WORD-1:0] redir_pc_q
`ifdef FETCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_pend_cycles,
    output logic [31:0]     perf_pred_taken
`endif
);

    typedef enum logic {RUN, PEND} state_t;

    state_t          state;
    logic [WORD-1:0] pend_pc;
    logic            pc_frozen;

    assign pc_frozen = stall_icache | stall_dcache;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pend_pc <= RESET_PC;
        end else begin
            // The most recent EX target always wins, whether it is taken now or replayed later.
            if (ex_branch) begin
                pend_pc <= ex_pc;
            end
            case (state)
                RUN:     if (ex_branch && pc_frozen) state <= PEND;
                PEND:    if (!pc_frozen)             state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        if0_pre_branch   = 1'b0;
        if0_pre_pc       = '0;
        if0_ex_branch    = 1'b0;
        if0_ex_pc        = '0;
        if0_pc_stall     = 1'b0;
        flush_if         = 1'b0;
        redirect_pending = 1'b0;
        redir_pc_q       = pend_pc;
        if (!rst) begin
            if0_pre_pc       = pre_pc;
            if0_ex_pc        = ex_branch ? ex_pc : pend_pc;
            redirect_pending = (state == PEND);
            case (state)
                RUN: begin
                    if (ex_branch) begin
                        // A live redirect flushes the load-dependent instruction, so stall_load is dropped.
                        flush_if      = 1'b1;
                        if0_ex_branch = !pc_frozen;
                        if0_pc_stall  = pc_frozen;
                    end else begin
                        if0_pc_stall   = pc_frozen | stall_load;
                        if0_pre_branch = pre_branch;
                    end
                end
                PEND: begin
                    if (pc_frozen) begin
                        if0_pc_stall = 1'b1;
                        flush_if     = ex_branch;
                    end else begin
                        // Release: replay the redirect and kill the stale word the ICache hands back.
                        if0_ex_branch = 1'b1;
                        flush_if      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_REDIRECT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects   <= '0;
            perf_pend_cycles <= '0;
            perf_pred_taken  <= '0;
        end else begin
            if (if0_ex_branch) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            // Only frozen waiting cycles count; the release cycle is counted as a redirect.
            if (state == PEND && pc_frozen) begin
                perf_pend_cycles <= perf_pend_cycles + 32'd1;
            end
            if (if0_pre_branch && !if0_pc_stall) begin
                perf_pred_taken <= perf_pred_taken + 32'd1;
            end
        end
    end
`endif

endmodule
